// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side bundle for the FIFO write arbiter: per-producer requests and
// data in, shared memory write port and status out.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ID_W      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic                         full;
  logic [NUM_REQ-1:0]           gnt;
  logic                         w_en;
  logic [DATA_SIZE-1:0]         data_in;
  logic [ID_W-1:0]              active_id;
  logic                         locked;
  logic [CNT_W-1:0]             stall_cnt;

  modport master (
    output req, req_data, full,
    input  gnt, w_en, data_in, active_id, locked, stall_cnt
  );

  modport slave (
    input  req, req_data, full,
    output gnt, w_en, data_in, active_id, locked, stall_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with burst locking; never writes while full and
// counts cycles in which requesters were blocked by full.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input logic              w_clk,
  input logic              w_rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int unsigned BcW = $clog2(BURST_LEN + 1);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [BcW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             owner_hold, owner_drop;
  logic [ID_W-1:0]  scan_ptr, cur;
  logic             scan_found;
  logic [ID_W:0]    scan_idx;
  logic             grant;
  logic [NUM_REQ-1:0] gnt;
  logic [BcW-1:0]   burst_inc;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) return '0;
    return id + ID_W'(1);
  endfunction

  assign owner_hold = (state_q == StLocked) && bus.req[owner_q];
  assign owner_drop = (state_q == StLocked) && !bus.req[owner_q];
  // A dropped owner hands the scan start to its successor in the same cycle.
  assign scan_ptr   = owner_drop ? next_id(owner_q) : rr_ptr_q;

  always_comb begin
    cur        = scan_ptr;
    scan_found = 1'b0;
    scan_idx   = '0;
    if (owner_hold) begin
      cur        = owner_q;
      scan_found = 1'b1;
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, scan_ptr} + (ID_W + 1)'(k);
      if (scan_idx >= (ID_W + 1)'(NUM_REQ)) scan_idx = scan_idx - (ID_W + 1)'(NUM_REQ);
      if (!scan_found && bus.req[scan_idx[ID_W-1:0]]) begin
        cur        = scan_idx[ID_W-1:0];
        scan_found = 1'b1;
      end
    end
  end

  assign grant = bus.req[cur] & ~bus.full & ~w_rst;

  always_comb begin
    gnt      = '0;
    gnt[cur] = grant;
  end

  assign bus.gnt       = gnt;
  assign bus.w_en      = grant;
  assign bus.data_in   = bus.req_data[cur*DATA_SIZE +: DATA_SIZE];
  assign bus.active_id = cur;
  assign bus.locked    = (state_q == StLocked);
  assign bus.stall_cnt = stall_cnt_q;

  assign burst_inc = burst_cnt_q + BcW'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    stall_cnt_d = stall_cnt_q;

    if (owner_drop) begin
      state_d     = StIdle;
      rr_ptr_d    = next_id(owner_q);
      burst_cnt_d = '0;
    end

    if (grant) begin
      if (owner_hold) begin
        if (burst_inc == BcW'(BURST_LEN)) begin
          state_d     = StIdle;
          rr_ptr_d    = next_id(owner_q);
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_inc;
        end
      end else if (BURST_LEN == 1) begin
        rr_ptr_d = next_id(cur);
      end else begin
        state_d     = StLocked;
        owner_d     = cur;
        burst_cnt_d = BcW'(1);
      end
    end

    if ((|bus.req) && bus.full && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule
